generate_hour: RTL and testbench
================================

Name: generate_hour

Overview:
Hours stage of the digital-clock chain. Holds the current hour as two BCD digits, tens in h1 and units in h2. It advances by one hour on each rising clk edge while key is high. It emits a one-cycle carry pulse, en_out, when the hour wraps, to drive a downstream day/AM-PM stage. In the system, clk is the hour tick; in the unit bench it is a 1 Hz clock.

Parameters:
MODE24, 1, 1 = 24-hour count 00..23; 0 = 12-hour count 12,01..11,12.

Ports:
clk     input   1  rising-edge clock; each edge is one potential hour step
reset   input   1  asynchronous, active-high reset
key     input   1  count enable, active-high; synchronous to clk, sampled on the rising edge; no internal synchronizer
h1      output  4  BCD tens digit of hour, registered
h2      output  4  BCD units digit of hour, registered
en_out  output  1  registered wrap pulse, high for exactly one clk cycle

Behaviour:
- Reset (reset=1, asynchronous, overrides everything):
  - MODE24=1: h1=0, h2=0.
  - MODE24=0: h1=1, h2=2 (12).
  - en_out=0 in both modes.
  - State is held while reset stays high.
- Reset deassertion is synchronous in effect: the first possible increment is the first rising edge after reset falls.
- Each rising edge with reset=0:
  - key=1: increment the hour by one.
  - key=0: hold h1/h2 and force en_out=0.
- BCD increment:
  - If h2=9: h2 goes to 0 and h1 goes to h1+1.
  - Otherwise: h2 goes to h2+1.
  - h1/h2 never hold values above 9.
  - No binary-to-BCD conversion: the counter is kept in BCD directly.
- 24-hour wrap (MODE24=1): from 23 with key=1, the next state is 00. en_out=1 during the cycle in which 00 is displayed; cleared on the next edge.
- 12-hour sequence (MODE24=0): 12 -> 01 -> 02 ... 09 -> 10 -> 11 -> 12.
  - The 12->01 step sets h1=0, h2=1.
  - en_out pulses for one cycle on the 11->12 transition (AM/PM toggle).
- en_out is high only in a cycle directly following an enabled wrap step. Two consecutive wraps can occur only 24 or 12 steps apart, so en_out is never high on two adjacent cycles.
- Illegal state recovery:
  - MODE24=1: any h1>2, h2>9, or h1=2 with h2>3 loads 00 on the next enabled edge.
  - MODE24=0: any state outside 01..12 loads 12.
  - en_out stays 0 on a recovery step.
- Reset mid-operation: outputs go immediately to their reset values. A pending en_out pulse is cancelled.
- Latency: the output reflects the new hour one clock edge after key is sampled high. No combinational path from key to any output.

Test Plan:
- Reset then count (MODE24=1, 1 Hz clock with rising edges at t=500,1500,… ms): reset=1 until 550 ms with key=1. Expect h1:h2=00 and en_out=0 during reset. Then one increment per edge: 01 at 1500 ms, up to 08 at 8500 ms.
- Hold: drop key to 0 at 9400 ms. Expect h1:h2 to stay 08 on every subsequent edge and en_out to remain 0.
- BCD carry: count from 09 with key=1. Expect 10, then 11; h2 never shows 10–15.
- 24-hour wrap: run from 22 with key=1. Expect 23, then 00 with en_out=1 for exactly one cycle, then 01 with en_out=0.
- 12-hour mode (MODE24=0): expect reset value 12. Run 24 edges: 12->01 with no pulse, 11->12 with en_out=1 for one cycle, and the sequence repeats.
- Async reset mid-count: assert reset between edges while showing 15. Expect h1:h2=00 immediately, before the next clk edge, and en_out=0.

Source files
------------

// File: rtl/generate_hour.sv
// Hours stage of the digital-clock chain: a two-digit BCD hour counter (24h or 12h)
// that emits a one-cycle carry pulse each time the hour wraps.
module generate_hour #(
    parameter bit MODE24 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic       en_out
);

    localparam logic [3:0] RST_H1 = MODE24 ? 4'd0 : 4'd1;
    localparam logic [3:0] RST_H2 = MODE24 ? 4'd0 : 4'd2;

    logic [3:0] h1_q, h1_d;
    logic [3:0] h2_q, h2_d;
    logic       en_q, en_d;
    logic       legal;
    logic       at_wrap;
    logic       at_twelve;

    always_comb begin
        legal     = 1'b0;
        at_wrap   = 1'b0;
        at_twelve = 1'b0;
        if (MODE24) begin
            legal   = (h2_q <= 4'd9) && ((h1_q < 4'd2) || (h1_q == 4'd2 && h2_q <= 4'd3));
            at_wrap = (h1_q == 4'd2) && (h2_q == 4'd3);
        end else begin
            legal     = ((h1_q == 4'd0) && (h2_q >= 4'd1) && (h2_q <= 4'd9)) ||
                        ((h1_q == 4'd1) && (h2_q <= 4'd2));
            // 11 -> 12 is the AM/PM carry; 12 -> 01 is a plain step with no pulse.
            at_wrap   = (h1_q == 4'd1) && (h2_q == 4'd1);
            at_twelve = (h1_q == 4'd1) && (h2_q == 4'd2);
        end
    end

    always_comb begin
        h1_d = h1_q;
        h2_d = h2_q;
        en_d = 1'b0;
        if (key) begin
            if (!legal) begin
                // Recovery from a corrupted state never signals a carry.
                h1_d = RST_H1;
                h2_d = RST_H2;
            end else if (at_wrap) begin
                h1_d = MODE24 ? 4'd0 : 4'd1;
                h2_d = MODE24 ? 4'd0 : 4'd2;
                en_d = 1'b1;
            end else if (at_twelve) begin
                h1_d = 4'd0;
                h2_d = 4'd1;
            end else if (h2_q == 4'd9) begin
                h1_d = h1_q + 4'd1;
                h2_d = 4'd0;
            end else begin
                h2_d = h2_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h1_q <= RST_H1;
            h2_q <= RST_H2;
            en_q <= 1'b0;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
            en_q <= en_d;
        end
    end

    assign h1     = h1_q;
    assign h2     = h2_q;
    assign en_out = en_q;

endmodule

// File: tb/tb_generate_hour.sv
// Bench for generate_hour: 24h and 12h instances checked every cycle against an
// integer-hour model, plus literal checkpoints from the test plan.
`timescale 1ms/1us
module tb_generate_hour;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key = 1'b0;
    logic [3:0] a_h1, a_h2, b_h1, b_h2;
    logic       a_en, b_en;

    int checks = 0;
    int fails  = 0;
    bit cmp_on = 1'b0;

    // Model state: plain hour numbers and pending carry flags.
    int hr24 = 0;
    int hr12 = 12;
    bit en24 = 1'b0;
    bit en12 = 1'b0;

    generate_hour #(.MODE24(1'b1)) dut24 (
        .clk(clk), .reset(reset), .key(key), .h1(a_h1), .h2(a_h2), .en_out(a_en)
    );
    generate_hour #(.MODE24(1'b0)) dut12 (
        .clk(clk), .reset(reset), .key(key), .h1(b_h1), .h2(b_h2), .en_out(b_en)
    );

    always #500 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hr24 = 0;
            hr12 = 12;
            en24 = 1'b0;
            en12 = 1'b0;
        end else if (key) begin
            hr24 = (hr24 + 1) % 24;
            en24 = (hr24 == 0);
            hr12 = (hr12 % 12) + 1;
            en12 = (hr12 == 12);
        end else begin
            en24 = 1'b0;
            en12 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m24_hour", {24'd0, a_h1, a_h2}, {24'd0, 4'(hr24 / 10), 4'(hr24 % 10)});
            chk("m24_en", 32'(a_en), 32'(en24));
            chk("m12_hour", {24'd0, b_h1, b_h2}, {24'd0, 4'(hr12 / 10), 4'(hr12 % 10)});
            chk("m12_en", 32'(b_en), 32'(en12));
            $display("t=%0t key=%0b 24h=%0d%0d en=%0b 12h=%0d%0d en=%0b",
                     $time, key, a_h1, a_h2, a_en, b_h1, b_h2, b_en);
        end
    end

    task automatic wait_show(input bit m24, input int hh, input int budget, input string nm);
        int n = 0;
        while (n < budget && !(m24 ? (a_h1 == 4'(hh / 10) && a_h2 == 4'(hh % 10))
                                   : (b_h1 == 4'(hh / 10) && b_h2 == 4'(hh % 10)))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: hour %0d not reached within %0d cycles", nm, hh, budget);
        end
    endtask

    initial begin
        key = 1'b1;
        #10 reset = 1'b1;
        cmp_on = 1'b1;
        #290;  // t=300, inside reset
        chk("rst24_h1", 32'(a_h1), 0);
        chk("rst24_h2", 32'(a_h2), 0);
        chk("rst24_en", 32'(a_en), 0);
        chk("rst12_h1", 32'(b_h1), 1);
        chk("rst12_h2", 32'(b_h2), 2);
        #250 reset = 1'b0;  // t=550
        #1050;              // t=1600
        chk("first24", {24'd0, a_h1, a_h2}, 32'h01);
        chk("first12", {24'd0, b_h1, b_h2}, 32'h01);
        chk("first12_en", 32'(b_en), 0);
        #7000;              // t=8600
        chk("cnt24_08", {24'd0, a_h1, a_h2}, 32'h08);
        #800 key = 1'b0;    // t=9400
        #2200;              // t=11600, three edges held
        chk("hold24", {24'd0, a_h1, a_h2}, 32'h08);
        chk("hold24_en", 32'(a_en), 0);
        #400 key = 1'b1;    // t=12000
        #2600;              // t=14600: 09, 10, 11
        chk("bcd24_11", {24'd0, a_h1, a_h2}, 32'h11);

        wait_show(1'b1, 22, 40, "reach22");
        @(negedge clk);
        chk("w24_23", {24'd0, a_h1, a_h2}, 32'h23);
        chk("w24_23en", 32'(a_en), 0);
        @(negedge clk);
        chk("w24_00", {24'd0, a_h1, a_h2}, 32'h00);
        chk("w24_00en", 32'(a_en), 1);
        @(negedge clk);
        chk("w24_01", {24'd0, a_h1, a_h2}, 32'h01);
        chk("w24_01en", 32'(a_en), 0);

        wait_show(1'b0, 11, 30, "reach11");
        @(negedge clk);
        chk("w12_12", {24'd0, b_h1, b_h2}, 32'h12);
        chk("w12_12en", 32'(b_en), 1);
        @(negedge clk);
        chk("w12_01", {24'd0, b_h1, b_h2}, 32'h01);
        chk("w12_01en", 32'(b_en), 0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            key = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                #100 reset = 1'b1;
                #50 reset = 1'b0;
            end
        end

        key = 1'b1;
        wait_show(1'b1, 15, 40, "reach15");
        #100 reset = 1'b1;
        #1;
        chk("async24", {24'd0, a_h1, a_h2}, 32'h00);
        chk("async24_en", 32'(a_en), 0);
        chk("async12", {24'd0, b_h1, b_h2}, 32'h12);
        #100 reset = 1'b0;
        @(negedge clk);
        chk("post_rst24", {24'd0, a_h1, a_h2}, 32'h01);
        @(negedge clk);
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
